// File: rtl/display_arbiter_pkg.sv
// Shared encodings for the scanned 7-segment display blocks: arbiter states,
// one-hot grant values and requester identifiers.
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      ST_GRANT_A: grant_of = GRANT_A;
      ST_GRANT_B: grant_of = GRANT_B;
      default:    grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/display_arbiter_scan_timer.sv
// Digit-scan timer: divides clk into per-digit slot strobes and groups
// three slots into a frame.
module scan_timer #(
  parameter int SCAN_DIV = 4000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       scan_tick,
  output logic [1:0] slot,
  output logic       frame_end
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      slot    <= 2'd0;
    end else begin
      if (div_cnt == CNT_MAX) begin
        div_cnt <= '0;
        slot    <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  assign scan_tick = (div_cnt == CNT_MAX);
  assign frame_end = scan_tick && (slot == 2'd2);

endmodule

// File: rtl/display_arbiter.sv
// Frame-synchronous arbiter sharing the 3-digit display between two 8-bit
// requesters; ownership and displayed value only change at frame ends.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int SCAN_DIV    = 4000,
  parameter int HOLD_FRAMES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic       scan_tick,
  output logic       frame_end,
  output logic [7:0] disp_data,
  output logic       disp_blank,
  output logic [1:0] grant
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

  // Handshake: req_x is a level held with data_x stable until ack_x; ack_x is
  // a one-cycle pulse on every latch of data_x, issued only at frame ends.

  arb_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  src_t              last_grant;
  logic              latch_a, latch_b;
  logic [1:0]        slot;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
    .clk       (clk),
    .reset     (reset),
    .scan_tick (scan_tick),
    .slot      (slot),
    .frame_end (frame_end)
  );

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    latch_a    = 1'b0;
    latch_b    = 1'b0;
    if (frame_end) begin
      case (state)
        ST_IDLE: begin
          if (req_a && (!req_b || last_grant == SRC_B)) begin
            state_next = ST_GRANT_A;
            hold_next  = '0;
            latch_a    = 1'b1;
          end else if (req_b) begin
            state_next = ST_GRANT_B;
            hold_next  = '0;
            latch_b    = 1'b1;
          end
        end
        ST_GRANT_A: begin
          // A yields only when it drops or its hold has expired with B waiting.
          if (req_b && (!req_a || hold_cnt == HOLD_MAX)) begin
            state_next = ST_GRANT_B;
            hold_next  = '0;
            latch_b    = 1'b1;
          end else if (!req_a) begin
            state_next = ST_IDLE;
          end else begin
            if (hold_cnt != HOLD_MAX) hold_next = hold_cnt + HOLD_W'(1);
            latch_a = 1'b1;
          end
        end
        ST_GRANT_B: begin
          if (req_a && (!req_b || hold_cnt == HOLD_MAX)) begin
            state_next = ST_GRANT_A;
            hold_next  = '0;
            latch_a    = 1'b1;
          end else if (!req_b) begin
            state_next = ST_IDLE;
          end else begin
            if (hold_cnt != HOLD_MAX) hold_next = hold_cnt + HOLD_W'(1);
            latch_b = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      last_grant <= SRC_B;
      disp_data  <= 8'h00;
      disp_blank <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      ack_a    <= latch_a;
      ack_b    <= latch_b;
      if (latch_a) begin
        disp_data  <= data_a;
        disp_blank <= 1'b0;
        last_grant <= SRC_A;
      end else if (latch_b) begin
        disp_data  <= data_b;
        disp_blank <= 1'b0;
        last_grant <= SRC_B;
      end
    end
  end

  assign grant = grant_of(state);

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized bench for display_arbiter against a frame-level behavioural model.
module tb_display_arbiter;

  localparam int SD = 4;
  localparam int HF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b;
  logic       scan_tick, frame_end;
  logic [7:0] disp_data;
  logic       disp_blank;
  logic [1:0] grant;

  int tests = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  display_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .data_a     (data_a),
    .ack_a      (ack_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .ack_b      (ack_b),
    .scan_tick  (scan_tick),
    .frame_end  (frame_end),
    .disp_data  (disp_data),
    .disp_blank (disp_blank),
    .grant      (grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = A, 2 = B; cyc counts edges since reset.
  int         cyc;
  int         m_owner, m_frames, m_last;
  logic [7:0] m_disp;
  logic       m_blank;
  logic       m_ack [1:2];
  logic       rq [1:2];
  logic [7:0] dt [1:2];

  task automatic m_take(input int who);
    m_owner  = who;
    m_frames = 0;
    m_last   = who;
    m_disp   = dt[who];
    m_blank  = 1'b0;
    m_ack[who] = 1'b1;
  endtask

  task automatic m_keep(input int who);
    if (m_frames < HF - 1) m_frames++;
    m_disp  = dt[who];
    m_blank = 1'b0;
    m_ack[who] = 1'b1;
  endtask

  task automatic model_edge();
    int other;
    m_ack[1] = 1'b0;
    m_ack[2] = 1'b0;
    if (reset) begin
      cyc = 0; m_owner = 0; m_frames = 0; m_last = 2;
      m_disp = 8'h00; m_blank = 1'b1;
    end else begin
      rq[1] = req_a; rq[2] = req_b;
      dt[1] = data_a; dt[2] = data_b;
      if (cyc % (3 * SD) == 3 * SD - 1) begin
        if (m_owner == 0) begin
          if (rq[1] && rq[2]) m_take(3 - m_last);
          else if (rq[1]) m_take(1);
          else if (rq[2]) m_take(2);
        end else begin
          other = 3 - m_owner;
          if (!rq[m_owner]) begin
            if (rq[other]) m_take(other);
            else m_owner = 0;
          end else if (m_frames < HF - 1) begin
            m_keep(m_owner);
          end else if (rq[other]) begin
            m_take(other);
          end else begin
            m_keep(m_owner);
          end
        end
      end
      cyc++;
    end
  endtask

  // driver: one clock, then compare all outputs 1ns after the edge
  task automatic step();
    logic [1:0] exp_grant;
    @(posedge clk);
    model_edge();
    #1;
    exp_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    check("scan_tick", 32'(scan_tick), 32'(cyc % SD == SD - 1));
    check("frame_end", 32'(frame_end), 32'(cyc % (3 * SD) == 3 * SD - 1));
    check("grant", 32'(grant), 32'(exp_grant));
    check("disp_data", 32'(disp_data), 32'(m_disp));
    check("disp_blank", 32'(disp_blank), 32'(m_blank));
    check("ack_a", 32'(ack_a), 32'(m_ack[1]));
    check("ack_b", 32'(ack_b), 32'(m_ack[2]));
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    data_a = 8'd0; data_b = 8'd0;
    m_ack[1] = 1'b0; m_ack[2] = 1'b0;
    step();
    step();

    // idle scan timing with no requests
    reset = 1'b0;
    repeat (30) step();

    // single requester, then contention from reset
    reset = 1'b1; step();
    reset = 1'b0; req_a = 1'b1; data_a = 8'd123;
    repeat (20) step();
    reset = 1'b1; step();
    reset = 1'b0; req_b = 1'b1; data_b = 8'd45;
    repeat (15) step();
    data_a = 8'd200;
    repeat (70) step();
    req_a = 1'b0;
    repeat (30) step();
    req_b = 1'b0;
    repeat (20) step();

    // reset mid-grant
    req_a = 1'b1;
    repeat (18) step();
    reset = 1'b1; step();
    reset = 1'b0; req_a = 1'b0;
    repeat (10) step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) req_a = ~req_a;
      if ($urandom_range(0, 29) == 0) req_b = ~req_b;
      if ($urandom_range(0, 7) == 0) data_a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) data_b = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
